// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - five-voter ballot session controller feeding a 3-of-5 majority result
//
// Opens a session on start, accepts one vote per voter (first vote wins),
// then evaluates the frozen ballot for one cycle and presents a registered
// yes-count and majority result.
//
// Optional feature: define VOTE_TIMEOUT_EN to force the session closed after
// TIMEOUT collect cycles. Voters who have not voted by then count as no.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      opens a session (sampled in IDLE and RESULT)
//   vote_valid per-voter vote strobe
//   vote_val   per-voter vote value (1 = yes)
//   ballot     latched vote values
//   voted      per-voter accepted flags
//   busy       high in COLLECT and EVAL
//   done       one-cycle pulse when result/yes_count update
//   result     yes_count >= 3
//   yes_count  number of yes votes, 0..5
//   timed_out  last session closed by timeout
module vote_session_ctrl #(
    parameter int TIMEOUT   = 1000,
    parameter int TIMEOUT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] vote_valid,
    input  logic [4:0] vote_val,
    output logic [4:0] ballot,
    output logic [4:0] voted,
    output logic       busy,
    output logic       done,
    output logic       result,
    output logic [2:0] yes_count,
    output logic       timed_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [4:0] accept;
    logic [4:0] ballot_next;
    logic [4:0] voted_next;
    logic [2:0] pop;
    logic       clear;
    logic       expire;
    logic       tmo_hit;

    // Ballot popcount; five 1-bit terms cannot overflow 3 bits.
    assign pop = 3'(ballot[0]) + 3'(ballot[1]) + 3'(ballot[2])
               + 3'(ballot[3]) + 3'(ballot[4]);

    assign busy = (state == COLLECT) || (state == EVAL);

    always_comb begin
        state_next  = state;
        ballot_next = ballot;
        voted_next  = voted;
        accept      = vote_valid & ~voted;
        clear       = 1'b0;
        expire      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                    clear      = 1'b1;
                end
            end
            COLLECT: begin
                voted_next  = voted | accept;
                ballot_next = (ballot & ~accept) | (vote_val & accept);
                // Completion is judged on the post-acceptance flags so the
                // final vote and the close happen on the same edge.
                if (&voted_next) begin
                    state_next = EVAL;
                end else if (tmo_hit) begin
                    state_next = EVAL;
                    expire     = 1'b1;
                end
            end
            EVAL: begin
                state_next = RESULT;
            end
            RESULT: begin
                if (start) begin
                    state_next = COLLECT;
                    clear      = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clear) begin
            ballot_next = 5'd0;
            voted_next  = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ballot    <= 5'd0;
            voted     <= 5'd0;
            done      <= 1'b0;
            result    <= 1'b0;
            yes_count <= 3'd0;
        end else begin
            state  <= state_next;
            ballot <= ballot_next;
            voted  <= voted_next;
            done   <= (state == EVAL);
            if (state == EVAL) begin
                yes_count <= pop;
                result    <= (pop >= 3'd3);
            end
        end
    end

`ifdef VOTE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 timed_out_r;

    // Counter holds the number of completed COLLECT cycles, so the edge that
    // ends the TIMEOUT-th cycle sees TIMEOUT-1.
    assign tmo_hit   = (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1));
    assign timed_out = timed_out_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timed_out_r <= 1'b0;
        end else if (clear) begin
            tmo_cnt     <= '0;
            timed_out_r <= 1'b0;
        end else if (state == COLLECT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (expire) begin
                timed_out_r <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign timed_out  = 1'b0;
    assign unused_tmo = ^{32'(TIMEOUT), 32'(TIMEOUT_W), expire, clear};
`endif

endmodule
